// File: rtl/shift_iter_if.sv
// Request/response bundle between decode, the iterative shift unit and writeback.
interface shift_iter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, data_in, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, op, data_in, shamt,
    output busy, done, result
  );
endinterface

// File: rtl/shift_iter_unit.sv
// Iterative shifter: one bit position per cycle, registered result plus a
// single-cycle done pulse. Supports SLL, SRL, SRA and rotate-right.
module shift_iter_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic         clk,
  input  logic         reset,
  shift_iter_if.slave  sif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] work, work_n;
  logic [WIDTH-1:0] res, res_n;
  logic [SHW-1:0]   cnt, cnt_n;
  logic [1:0]       opr, opr_n;
  logic [WIDTH-1:0] step;

  function automatic logic [WIDTH-1:0] shift_step(input logic [1:0] o,
                                                  input logic [WIDTH-1:0] w);
    case (o)
      2'b00:   return {w[WIDTH-2:0], 1'b0};
      2'b01:   return {1'b0, w[WIDTH-1:1]};
      2'b10:   return {w[WIDTH-1], w[WIDTH-1:1]};
      default: return {w[0], w[WIDTH-1:1]};
    endcase
  endfunction

  assign step = shift_step(opr, work);

  always_comb begin
    state_n = state;
    work_n  = work;
    cnt_n   = cnt;
    opr_n   = opr;
    res_n   = res;
    case (state)
      SHIFT: begin
        work_n = step;
        cnt_n  = cnt - SHW'(1);
        if (cnt == SHW'(1)) begin
          state_n = DONE;
          res_n   = step;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request, giving zero-bubble issue.
        state_n = IDLE;
        if (sif.start) begin
          work_n = sif.data_in;
          opr_n  = sif.op;
          cnt_n  = sif.shamt;
          if (sif.shamt == '0) begin
            state_n = DONE;
            res_n   = sif.data_in;
          end else begin
            state_n = SHIFT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      opr   <= '0;
      res   <= '0;
    end else begin
      state <= state_n;
      work  <= work_n;
      cnt   <= cnt_n;
      opr   <= opr_n;
      res   <= res_n;
    end
  end

  assign sif.busy   = (state == SHIFT);
  assign sif.done   = (state == DONE);
  assign sif.result = res;

endmodule
